// File: rtl/hp_au_pkg.sv
// Shared definitions for the HP-AU arithmetic unit and its two-requester front end.
package hp_au_pkg;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_BCD   = 3'd2;
  localparam logic [2:0] OP_CLA   = 3'd3;
  localparam logic [2:0] OP_AND   = 3'd4;
  localparam logic [2:0] OP_OR    = 3'd5;
  localparam logic [2:0] OP_XOR   = 3'd6;
  localparam logic [2:0] OP_SHIFT = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Single BCD digit add; the decimal carry out is dropped.
  function automatic logic [3:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > 5'd9) s = s + 5'd6;
    return s[3:0];
  endfunction

endpackage

// File: rtl/hp_au_top.sv
// Combinational HP-AU: full-width add/sub/logic ops plus nibble-wide BCD, CLA and shift paths.
module hp_au_top
  import hp_au_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] y
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;
  logic [3:0] w_cla;
  logic [3:0] w_sh;

  // Flattened carry-lookahead over the low nibble, carry-in zero.
  assign w_g   = a[3:0] & b[3:0];
  assign w_p   = a[3:0] ^ b[3:0];
  assign w_c[0] = 1'b0;
  assign w_c[1] = w_g[0];
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0]);
  assign w_cla = w_p ^ w_c;
  assign w_sh  = a[3:0] << b[1:0];

  always_comb begin
    y = '0;
    case (sel)
      OP_ADD:   y = a + b;
      OP_SUB:   y = a - b;
      OP_BCD:   y[3:0] = bcd_digit_add(a[3:0], b[3:0]);
      OP_CLA:   y[3:0] = w_cla;
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      default:  y[3:0] = w_sh;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the priority pointer is owned by the caller.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/hp_au_arbiter.sv
// Two-requester front end for the HP-AU: round-robin accept, one op in flight,
// registered result returned with requester id on a valid/ready channel.
module hp_au_arbiter
  import hp_au_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [5:0]         req_sel,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_id,
  output logic               busy
);

  state_t           r_state;
  logic             r_prio;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [2:0]       r_op_sel;
  logic             r_op_id;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_id;
  logic             r_rsp_valid;
  logic             r_busy;

  logic [1:0]       w_gnt;
  logic             w_gnt_id;
  logic             w_accept;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [2:0]       w_sel;
  logic [WIDTH-1:0] w_au_y;

  rr_arb2 u_arb (
    .req  (req_valid),
    .prio (r_prio),
    .gnt  (w_gnt)
  );

  // Gated by rst_n so no grant is offered while reset is held.
  assign req_ready = (rst_n && (r_state == ST_IDLE)) ? w_gnt : 2'b00;
  assign w_accept  = |(req_valid & req_ready);
  assign w_gnt_id  = w_gnt[1];
  assign w_a       = w_gnt_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
  assign w_b       = w_gnt_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
  assign w_sel     = w_gnt_id ? req_sel[5:3] : req_sel[2:0];

  hp_au_top #(.WIDTH(WIDTH)) u_au (
    .a   (r_op_a),
    .b   (r_op_b),
    .sel (r_op_sel),
    .y   (w_au_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_prio       <= 1'b0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_sel     <= '0;
      r_op_id      <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op_a   <= w_a;
            r_op_b   <= w_b;
            r_op_sel <= w_sel;
            r_op_id  <= w_gnt_id;
            r_prio   <= ~w_gnt_id;
            r_busy   <= 1'b1;
            r_state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_result <= w_au_y;
          r_rsp_id     <= r_op_id;
          r_rsp_valid  <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_id     = r_rsp_id;
  assign busy       = r_busy;

endmodule

// File: doc/hp_au_arbiter.md
# hp_au_arbiter

Two-requester front end for the HP-AU arithmetic unit. Arbitrates round-robin between two operation requesters. Registers the winner's operands and opcode, drives an internal `hp_au_top` instance, and returns the registered result with the requester ID over a valid/ready response channel. Only one operation is in flight at a time. It sits between the issue logic of two clients and the shared combinational AU.

## Interface
Parameters:
- `WIDTH`, 4, operand/result width; must be ≥ 4 (BCD/CLA/shift paths use bits [3:0], upper bits zero).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  2  bit i = requester i has an operation pending.
- `req_ready`  out  2  bit i = requester i's operation is accepted this cycle.
- `req_a`  in  2*WIDTH  operand a; requester i in bits [i*WIDTH +: WIDTH].
- `req_b`  in  2*WIDTH  operand b, packed the same way.
- `req_sel`  in  6  opcode; requester i in bits [i*3 +: 3].
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_result`  out  WIDTH  AU result for the accepted operation.
- `rsp_id`  out  1  index of the requester that issued it.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Opcodes: 0 add, 1 sub (both modulo 2^WIDTH), 2 BCD add (low digit), 3 CLA add (low nibble), 4 AND, 5 OR, 6 XOR, 7 barrel shift of a[3:0] by b[1:0].
- States:
  - IDLE: `req_ready` = one-hot grant among the valid requesters, or 00. Go to EXEC on `req_valid[g] & req_ready[g]`.
  - EXEC: unconditionally go to RESP.
  - RESP: go to IDLE on `rsp_ready`.
- Grant rules:
  - If only one requester is valid, it wins.
  - If both are valid, the requester named by priority pointer `prio` wins.
  - After a grant to requester i, `prio` becomes 1−i.
- On acceptance, register a, b, sel and id as `op_a`, `op_b`, `op_sel`, `op_id`. These feed the AU.
- In EXEC, the AU output is captured into `rsp_result` and `op_id` is copied to `rsp_id`.
- In RESP, `rsp_valid`=1, and `rsp_result`/`rsp_id` hold stable until the handshake completes.
- `req_ready` is 00 in EXEC and RESP. No request is accepted while an operation is outstanding.
- `req_valid` deasserting in IDLE before the handshake has no effect: nothing is latched.
- Reset values: state IDLE, `prio`=0, `req_ready`=00, `rsp_valid`=0, `rsp_result`=0, `rsp_id`=0, `busy`=0, operand registers 0.
- Reset asserted mid-operation: the in-flight operation is discarded and no response is produced after release.

## Timing
- Accept at edge N (handshake in cycle N−1 → EXEC in cycle N). Result registered at edge N+1. `rsp_valid` high from cycle N+1.
- Latency: 2 cycles from the acceptance cycle to the first `rsp_valid`.
- Response handshake in cycle M → IDLE in M+1 → next acceptance possible in M+1.
- Maximum throughput is one operation per 3 cycles.
- `req_ready` is combinational from `req_valid`, `prio` and state. It does not depend on `req_a`, `req_b` or `req_sel`.
- All other outputs are registered.
- `rsp_ready` high while `rsp_valid` is low is ignored.

## Structure
- Shared package `hp_au_pkg` holds:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_BCD=2, OP_CLA=3, OP_AND=4, OP_OR=5, OP_XOR=6, OP_SHIFT=7;
  - state encodings ST_IDLE, ST_EXEC, ST_RESP.
- Sub-module `rr_arb2`: takes `req[1:0]` and `prio` and returns the one-hot `gnt[1:0]`. It is purely combinational. The pointer stays in the parent.
- The `hp_au_top` instance lives inside this block. Its `sel` is driven only from `op_sel`.

## Test plan
- Reset:
  - Hold `rst_n`=0 with both `req_valid`=1.
  - Required: `req_ready`=00, `rsp_valid`=0, `rsp_result`=0, `busy`=0.
- Single request:
  - Requester 0 sends sel=0, a=3, b=4.
  - Required: accepted in the first IDLE cycle; `rsp_valid`=1 two cycles later with `rsp_result`=7, `rsp_id`=0.
- Contention:
  - After reset, hold both requesters valid; requester 0 sends AND a=C b=A, requester 1 sends XOR a=C b=A.
  - Required: responses in order id 0 (result 8), then id 1 (result 6), then alternating 0, 1, 0.
- Backpressure:
  - Hold `rsp_ready`=0 for 5 cycles in RESP.
  - Required: `rsp_result`/`rsp_id` stable, `req_ready`=00, `busy`=1; IDLE the cycle after `rsp_ready`=1.
- Arithmetic edges:
  - sel=0, a=9, b=7 → 0.
  - sel=1, a=2, b=5 → D.
  - sel=2, a=5, b=7 → 2.
  - sel=3, a=F, b=1 → 0.
- Reset mid-EXEC:
  - Pulse `rst_n` low for 1 cycle during EXEC.
  - Required: no `rsp_valid` follows; the next contended grant goes to requester 0.
